// File: rtl/ps2_host_tx_if.sv
// Command-side and pad-side signals of the PS/2 host transmitter.
// slave = the transmitter itself, master = the system/pads that feed it.
interface ps2_host_tx_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;
  logic       ps2k_clk_in;
  logic       ps2k_data_in;
  logic       ps2k_clk_oe;
  logic       ps2k_data_oe;

  modport slave (
    input  tx_byte, tx_start, ps2k_clk_in, ps2k_data_in,
    output tx_busy, tx_done, tx_error, rx_inhibit, ps2k_clk_oe, ps2k_data_oe
  );

  modport master (
    output tx_byte, tx_start, ps2k_clk_in, ps2k_data_in,
    input  tx_busy, tx_done, tx_error, rx_inhibit, ps2k_clk_oe, ps2k_data_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11-bit frame, ack, idle-wait.
// Pad edges reach the FSM 2+FILTER_LEN cycles late; tx_start is dropped (not queued) while busy.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 4
) (
  input  logic          CLK_50M,
  input  logic          RSTn,
  ps2_host_tx_if.slave  bus
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Index 0 = clock line, index 1 = data line.
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0]            filt_q, filt_d;
  logic [1:0][FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic                  clk_prev_q, clk_prev_d;
  logic                  fall;

  state_t                state_q, state_d;
  logic [INH_W-1:0]      inh_q, inh_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [8:0]            shreg_q, shreg_d;
  logic                  ok_q, ok_d;
  logic                  data_oe_q, data_oe_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_comb begin
    sync1_d    = {bus.ps2k_data_in, bus.ps2k_clk_in};
    sync2_d    = sync1_q;
    clk_prev_d = filt_q[0];
    filt_d     = filt_q;
    flt_cnt_d  = '0;
    // A line only changes value after FILTER_LEN consecutive disagreeing samples.
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (flt_cnt_q[i] == FLT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          flt_cnt_d[i] = flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall = clk_prev_q & ~filt_q[0];

  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ok_d      = ok_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (state_q != S_IDLE) begin
      tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // The cycle carrying a done/error pulse is the return cycle; starts there are dropped.
        if (bus.tx_start && !done_q && !err_q) begin
          shreg_d   = {~^bus.tx_byte, bus.tx_byte};
          bit_cnt_d = '0;
          tmo_d     = '0;
          inh_d     = '0;
          ok_d      = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        inh_d = inh_q + 1'b1;
        if (inh_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[8:1]};
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          ok_d    = ~filt_q[1];
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q == 2'b11) begin
          done_d  = ok_q;
          err_d   = ~ok_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Timeout overrides whatever the frame was doing and skips the idle-wait.
    if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      flt_cnt_q  <= '0;
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      inh_q      <= '0;
      tmo_q      <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ok_q       <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      inh_q      <= inh_d;
      tmo_q      <= tmo_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ok_q       <= ok_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.tx_busy      = (state_q != S_IDLE);
  assign bus.rx_inhibit   = (state_q != S_IDLE);
  assign bus.tx_done      = done_q;
  assign bus.tx_error     = err_q;
  assign bus.ps2k_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign bus.ps2k_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and a
// timeline model of each transaction is compared against the outputs every cycle.
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TMO = 20000;
  localparam int FLT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Transaction model shared between stimulus and compare process.
  bit active = 1'b0;
  bit exp_ok = 1'b0;
  bit tmo_mode = 1'b0;
  int acc_cyc = 0;
  int rel_cyc = -1;

  ps2_host_tx_if bus();

  assign bus.ps2k_clk_in  = ~(bus.ps2k_clk_oe | dev_clk_low);
  assign bus.ps2k_data_in = ~(bus.ps2k_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .CLK_50M(clk),
    .RSTn(rst_n),
    .bus(bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dut=%0h model=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected 10 bits seen by the device: {stop, parity, data[7:0]}.
  function automatic logic [9:0] frame_bits(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  function automatic logic [5:0] outs();
    return {bus.tx_busy, bus.rx_inhibit, bus.ps2k_clk_oe, bus.ps2k_data_oe,
            bus.tx_done, bus.tx_error};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (!active) begin
        chk("idle_outs", outs(), 6'b000000);
      end else begin
        int n;
        n = cyc - acc_cyc;
        if (n < INH) begin
          chk("inhibit_outs", outs(), 6'b111000);
        end else if (n == INH) begin
          chk("req_outs", outs(), 6'b111100);
        end else if (bus.tx_busy) begin
          chk("send_outs", {bus.tx_busy, bus.rx_inhibit, bus.ps2k_clk_oe,
                            bus.tx_done, bus.tx_error}, 5'b11000);
          if (n >= TMO) chk("tmo_overrun", bus.tx_busy, 1'b0);
        end else begin
          chk("end_outs", outs(), {4'b0000, exp_ok, ~exp_ok});
          if (tmo_mode) chk("tmo_cycle", n, TMO);
          else          chk("end_lag", cyc - rel_cyc, FLT + 3);
          active = 1'b0;
        end
      end
    end
  end

  task automatic start(input logic [7:0] b, input bit ok, input bit tmo);
    @(negedge clk);
    exp_ok   = ok;
    tmo_mode = tmo;
    rel_cyc  = -1;
    acc_cyc  = cyc + 1;
    active   = 1'b1;
    bus.tx_byte  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    bus.tx_byte  = ~b;
  endtask

  // Device: waits for request-to-send, clocks 11 times, samples on rising edges.
  task automatic device_rx(input int half, input bit ack, input bit dup, input int abort_at,
                           output logic [9:0] got);
    int w = 0;
    got = '0;
    while (!(bus.ps2k_clk_in && !bus.ps2k_data_in) && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("req_seen", (w < 400), 1'b1);
    if (w >= 400) return;
    repeat (half) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk_low = 1'b1;
      if (dup && k == 3) begin
        bus.tx_byte  = 8'h55;
        bus.tx_start = 1'b1;
      end
      if (k == abort_at) begin
        repeat (20) @(negedge clk);
        bus.tx_start = 1'b0;
        return;
      end
      repeat (half) begin
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
      dev_clk_low = 1'b0;
      if (k <= 10) got[k-1] = bus.ps2k_data_in;
      if (k == 11 && !ack) rel_cyc = cyc;
      repeat (half / 2) @(negedge clk);
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11 && ack) begin
        dev_data_low = 1'b0;
        rel_cyc = cyc;
      end
      repeat (half - half / 2) @(negedge clk);
    end
  endtask

  task automatic wait_end(input int bound);
    int i = 0;
    while (active && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("end_seen", active, 1'b0);
    active = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b, input int half, input bit ack, input bit dup,
                       input logic [9:0] exp_w, input string nm);
    logic [9:0] got;
    start(b, ack, 1'b0);
    device_rx(half, ack, dup, 0, got);
    chk(nm, got, exp_w);
    wait_end(300);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [9:0] got;
    bus.tx_start = 1'b0;
    bus.tx_byte  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 6'b000000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    frame(8'hED, 200, 1'b1, 1'b0, 10'h3ED, "bits_ED");
    frame(8'h00, 120, 1'b1, 1'b0, 10'h300, "bits_00");
    frame(8'h01, 120, 1'b1, 1'b0, 10'h201, "bits_01");
    frame(8'hFF, 120, 1'b1, 1'b0, 10'h3FF, "bits_FF");
    frame(8'hA5, 120, 1'b0, 1'b0, frame_bits(8'hA5), "bits_noack");
    frame(8'h3C, 120, 1'b1, 1'b1, frame_bits(8'h3C), "bits_dup_start");

    // Device never clocks: only the timeout can end this transaction.
    start(8'h96, 1'b0, 1'b1);
    wait_end(TMO + 100);
    repeat (10) @(negedge clk);

    // Reset while the device holds the 5th clock low.
    start(8'hC3, 1'b1, 1'b0);
    device_rx(120, 1'b1, 1'b0, 5, got);
    active = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("reset_abort", outs(), 6'b000000);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    frame(8'hED, 120, 1'b1, 1'b0, 10'h3ED, "bits_after_reset");

    for (int r = 0; r < 4; r++) begin
      logic [7:0] b;
      int half;
      bit ack;
      b    = 8'($urandom_range(0, 255));
      half = int'($urandom_range(100, 180));
      ack  = ($urandom_range(0, 3) != 0);
      frame(b, half, ack, 1'b0, frame_bits(b), "bits_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends command bytes to the keyboard on the shared ps2k_clk/ps2k_data lines, for example 0xED followed by an LED mask, or 0xFF for reset. It is the outbound counterpart of the existing ps2 receive path and sits beside ps2_top under top_greedy_snake. Open-drain drive is expressed as output-enable signals: the pad drives low when an enable is 1 and is released (pulled up) when it is 0.

Parameters:
INHIBIT_CYCLES, 5000, clock-low inhibit time in CLK_50M cycles (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, maximum cycles from leaving IDLE until ack or idle-wait completes (20 ms)
FILTER_LEN, 4, number of consecutive equal synchronised samples required to change the filtered clock or data value

Ports:
CLK_50M  in  1  system clock, 50 MHz
RSTn  in  1  reset, asynchronous, active-low
tx_byte  in  8  command byte; sampled on the cycle tx_start is accepted
tx_start  in  1  single-cycle request; accepted only in IDLE
tx_busy  out  1  high from the cycle after acceptance until return to IDLE
tx_done  out  1  one-cycle pulse: frame completed and acknowledged
tx_error  out  1  one-cycle pulse: timeout or missing ack
rx_inhibit  out  1  equals tx_busy; the receive path must discard bits while it is high
ps2k_clk_in  in  1  raw PS/2 clock pad input
ps2k_data_in  in  1  raw PS/2 data pad input
ps2k_clk_oe  out  1  1 = pull clock line low
ps2k_data_oe  out  1  1 = pull data line low

Behaviour:
- Reset (asynchronous, RSTn=0): all outputs are 0 and both lines are released.
  - The FSM goes to IDLE.
  - The filtered clock and filtered data values reset to 1.
  - A reset mid-frame releases the lines immediately, with no done/error pulse.
- Input conditioning:
  - 2-flop synchroniser on each pad input, then the FILTER_LEN filter.
  - fall = one-cycle pulse when filtered clock goes 1->0.
  - Latency from pad edge to fall is 2+FILTER_LEN cycles.
- Frame: 11 bits.
  - Start bit 0, then data bits 0..7 LSB first.
  - Parity bit = odd parity, i.e. ~^tx_byte.
  - Stop bit 1 (line released), then the device ack.
- FSM states and transitions:
  - IDLE: on tx_start, latch tx_byte and parity into a 9-bit shift register, clear the bit counter, clear the timeout counter, go to INHIBIT. tx_busy=1 from the next cycle.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: data_oe=1 for one cycle with clk_oe still 1, then clk_oe=0 and go to SEND. This start bit stays asserted.
  - SEND: on each fall, drive the next bit: data_oe = ~bit.
    - Falls 1..8 drive data bits 0..7.
    - Fall 9 drives parity.
    - Fall 10 sets data_oe=0 (stop bit).
    - Data changes only on the cycle after a fall pulse.
    - The 4-bit counter increments per fall; go to ACK after fall 10.
  - ACK: on fall 11, sample filtered data.
    - 0 = ack ok, go to WAIT_IDLE with ok flag set.
    - 1 = no ack, go to WAIT_IDLE with ok flag clear.
  - WAIT_IDLE: wait until filtered clock=1 and filtered data=1 together, then go to IDLE.
    - tx_done pulses if the ok flag is set; otherwise tx_error pulses.
    - The pulse occurs in the same cycle the FSM enters IDLE; tx_busy drops then.
- Timeout:
  - The counter runs in every non-IDLE state.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE (the idle-wait is skipped).
  - The counter saturates and never wraps.
- tx_done and tx_error are never high in the same cycle.
- A tx_start while tx_busy=1 is ignored; no queueing.
- A tx_start on the exact cycle of return to IDLE is ignored; acceptance requires the FSM to be in IDLE with tx_busy=0.
- ps2k_clk_oe=1 only in INHIBIT and REQ. The host never drives clock during SEND or ACK.
- Line activity seen while IDLE is ignored; that traffic belongs to the receive path.

Test Plan:
(Bench sets INHIBIT_CYCLES=50, TIMEOUT_CYCLES=20000, FILTER_LEN=4, and uses a device model clocking at ~200 cycles per half period.)
- Inhibit timing: tx_start with tx_byte=0xED -> clk_oe high for exactly 50 cycles; data_oe rises 1 cycle before clk_oe falls; tx_busy=1 and rx_inhibit=1 from the cycle after tx_start.
- Full frame 0xED: device model samples on rising clock edges -> bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1; device acks low -> exactly one tx_done pulse, tx_error stays 0, tx_busy returns to 0.
- Parity coverage: 0x00 -> parity 1; 0x01 -> parity 0; 0xFF -> parity 1; each checked by the device model.
- No ack: device leaves data high on the 11th clock -> one tx_error pulse after the lines idle, no tx_done.
- Timeout: device model never clocks -> tx_error pulses 20000 cycles after tx_start acceptance; clk_oe=0, data_oe=0, state IDLE.
- Busy and reset: a second tx_start mid-frame is ignored and the first frame still completes correctly; a separate run asserts RSTn=0 at fall 5 -> both oe outputs 0 within the same cycle, no pulses, and a new tx_start after reset transmits normally.
